// File: rtl/mydiv_axis_if.sv
// Operand and result channels between the execute stage and the divider.
// The execute stage is the master; the divider is the slave.
interface mydiv_axis_if;
  logic [31:0] s_axis_dividend_tdata;
  logic        s_axis_dividend_tvalid;
  logic        s_axis_dividend_tready;
  logic [31:0] s_axis_divisor_tdata;
  logic        s_axis_divisor_tvalid;
  logic        s_axis_divisor_tready;
  logic [63:0] m_axis_dout_tdata;
  logic        m_axis_dout_tvalid;

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid
  );

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid
  );
endinterface

// File: rtl/mydiv_axis.sv
// Iterative 32-bit radix-2 restoring divider, one quotient bit per cycle.
// Result {quotient, remainder} pulses valid once, 33 cycles after the last operand.
module mydiv_axis #(
  parameter bit SIGNED = 1'b0
) (
  input logic         clk,
  input logic         reset,
  mydiv_axis_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic        dvd_cap_q, dvs_cap_q;
  logic [31:0] dvd_raw_q, dvs_raw_q;
  logic [31:0] quo_q;       // dividend magnitude shifting out, quotient shifting in
  logic [31:0] dvs_mag_q;
  logic [32:0] rem_q;
  logic [5:0]  cnt_q;
  logic        q_neg_q, r_neg_q;
  logic [63:0] dout_q;
  logic        dout_valid_q;

  logic        dvd_hs, dvs_hs, start, dvd_neg, dvs_neg, fits;
  logic [31:0] dvd_now, dvs_now, quo_next, quo_fix, rem_fix;
  logic [32:0] rem_shift, rem_next;
  logic [63:0] result;

  assign bus.s_axis_dividend_tready = (state_q == StIdle) && !dvd_cap_q;
  assign bus.s_axis_divisor_tready  = (state_q == StIdle) && !dvs_cap_q;
  assign bus.m_axis_dout_tdata      = dout_q;
  assign bus.m_axis_dout_tvalid     = dout_valid_q;

  always_comb begin
    dvd_hs  = bus.s_axis_dividend_tvalid && bus.s_axis_dividend_tready;
    dvs_hs  = bus.s_axis_divisor_tvalid && bus.s_axis_divisor_tready;
    // Operand accepted on this very edge is used directly.
    dvd_now = dvd_cap_q ? dvd_raw_q : bus.s_axis_dividend_tdata;
    dvs_now = dvs_cap_q ? dvs_raw_q : bus.s_axis_divisor_tdata;
    start   = (state_q == StIdle) && (dvd_cap_q || dvd_hs) && (dvs_cap_q || dvs_hs);
    dvd_neg = SIGNED && dvd_now[31];
    dvs_neg = SIGNED && dvs_now[31];

    rem_shift = {rem_q[31:0], quo_q[31]};
    fits      = rem_shift >= {1'b0, dvs_mag_q};
    rem_next  = fits ? rem_shift - {1'b0, dvs_mag_q} : rem_shift;
    quo_next  = {quo_q[30:0], fits};
    quo_fix   = q_neg_q ? -quo_next : quo_next;
    rem_fix   = r_neg_q ? -rem_next[31:0] : rem_next[31:0];
    // Divide by zero reports raw bits and bypasses the sign fix-up.
    result    = (dvs_raw_q == 32'd0) ? {32'hFFFF_FFFF, dvd_raw_q} : {quo_fix, rem_fix};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dvd_cap_q    <= 1'b0;
      dvs_cap_q    <= 1'b0;
      cnt_q        <= 6'd0;
      dout_q       <= 64'd0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (dvd_hs) begin
            dvd_cap_q <= 1'b1;
            dvd_raw_q <= bus.s_axis_dividend_tdata;
          end
          if (dvs_hs) begin
            dvs_cap_q <= 1'b1;
            dvs_raw_q <= bus.s_axis_divisor_tdata;
          end
          if (start) begin
            quo_q     <= dvd_neg ? -dvd_now : dvd_now;
            dvs_mag_q <= dvs_neg ? -dvs_now : dvs_now;
            q_neg_q   <= dvd_neg ^ dvs_neg;
            r_neg_q   <= dvd_neg;
            rem_q     <= 33'd0;
            cnt_q     <= 6'd0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            dout_q       <= result;
            dout_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          dout_valid_q <= 1'b0;
          dvd_cap_q    <= 1'b0;
          dvs_cap_q    <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mydiv_axis.sv
// Scoreboard bench for mydiv_axis: unsigned and signed instances driven in lockstep,
// expected results from plain integer arithmetic, checked by a negedge monitor.
module tb_mydiv_axis;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  mydiv_axis_if bus_u();
  mydiv_axis_if bus_s();

  mydiv_axis #(.SIGNED(1'b0)) u_div_u (.clk(clk), .reset(reset), .bus(bus_u));
  mydiv_axis #(.SIGNED(1'b1)) u_div_s (.clk(clk), .reset(reset), .bus(bus_s));

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        q_u[$];
  exp_t        q_s[$];
  logic [63:0] last_u = 64'd0;
  logic [63:0] last_s = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic set_dvd(input logic v, input logic [31:0] d);
    bus_u.s_axis_dividend_tvalid = v;
    bus_u.s_axis_dividend_tdata  = d;
    bus_s.s_axis_dividend_tvalid = v;
    bus_s.s_axis_dividend_tdata  = d;
  endtask

  task automatic set_dvs(input logic v, input logic [31:0] d);
    bus_u.s_axis_divisor_tvalid = v;
    bus_u.s_axis_divisor_tdata  = d;
    bus_s.s_axis_divisor_tvalid = v;
    bus_s.s_axis_divisor_tdata  = d;
  endtask

  function automatic logic [3:0] readies();
    return {bus_u.s_axis_dividend_tready, bus_u.s_axis_divisor_tready,
            bus_s.s_axis_dividend_tready, bus_s.s_axis_divisor_tready};
  endfunction

  // Called at posedge+1. Divisor offered 'gap' cycles after the dividend.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int gap,
                       input bit hold, output int c0);
    bit   got_a, got_b, hs_a, hs_b;
    int   t;
    exp_t e;
    got_a = 0;
    got_b = 0;
    t     = 0;
    c0    = 0;
    set_dvd(1'b1, a);
    while (!(got_a && got_b)) begin
      if (!got_b && t >= gap) set_dvs(1'b1, b);
      @(negedge clk);
      hs_a = bus_u.s_axis_dividend_tvalid && bus_u.s_axis_dividend_tready;
      hs_b = bus_u.s_axis_divisor_tvalid && bus_u.s_axis_divisor_tready;
      if (got_a) check("dvd_ready_low_after_capture",
                       64'({bus_u.s_axis_dividend_tready, bus_s.s_axis_dividend_tready}), 64'd0);
      if (!got_b && t < gap) check("dvs_ready_high_while_waiting",
                       64'({bus_u.s_axis_divisor_tready, bus_s.s_axis_divisor_tready}), 64'd3);
      @(posedge clk);
      #1;
      if (hs_a) begin
        got_a = 1;
        set_dvd(1'b0, $urandom());
      end
      if (hs_b) begin
        got_b = 1;
        set_dvs(1'b0, $urandom());
      end
      t++;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got no handshake expected one within 200 cycles");
        set_dvd(1'b0, 32'd0);
        set_dvs(1'b0, 32'd0);
        return;
      end
    end
    c0     = cyc;
    e.cyc  = c0 + 32;
    e.data = ref_div(a, b, 1'b0);
    q_u.push_back(e);
    e.data = ref_div(a, b, 1'b1);
    q_s.push_back(e);
    if (hold) begin
      repeat (33) begin
        @(negedge clk);
        check("ready_low_while_busy", 64'(readies()), 64'd0);
      end
      @(posedge clk);
      #1;
      check("ready_high_after_done", 64'(readies()), 64'hF);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_u = 64'd0;
      last_s = 64'd0;
    end else begin
      if (bus_u.m_axis_dout_tvalid) begin
        if (q_u.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse_u got %h expected no pulse", bus_u.m_axis_dout_tdata);
        end else begin
          e = q_u.pop_front();
          check("dout_u", bus_u.m_axis_dout_tdata, e.data);
          check("latency_u", 64'(cyc), 64'(e.cyc));
        end
        last_u = bus_u.m_axis_dout_tdata;
      end else begin
        check("hold_u", bus_u.m_axis_dout_tdata, last_u);
      end
      if (bus_s.m_axis_dout_tvalid) begin
        if (q_s.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse_s got %h expected no pulse", bus_s.m_axis_dout_tdata);
        end else begin
          e = q_s.pop_front();
          check("dout_s", bus_s.m_axis_dout_tdata, e.data);
          check("latency_s", 64'(cyc), 64'(e.cyc));
        end
        last_s = bus_s.m_axis_dout_tdata;
      end else begin
        check("hold_s", bus_s.m_axis_dout_tdata, last_s);
      end
    end
  end

  initial begin
    int          c, prev;
    logic [31:0] a, b;
    int          gap, kind;
    set_dvd(1'b0, 32'd0);
    set_dvs(1'b0, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 64'(readies()), 64'hF);
    check("reset_valid", 64'({bus_u.m_axis_dout_tvalid, bus_s.m_axis_dout_tvalid}), 64'd0);
    check("reset_dout_u", bus_u.m_axis_dout_tdata, 64'd0);
    check("reset_dout_s", bus_s.m_axis_dout_tdata, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_op(32'd100, 32'd7, 0, 1'b1, c);
    prev = c;
    do_op(32'hFFFF_FFF9, 32'd2, 0, 1'b1, c);
    check("b2b_accept_edge", 64'(c), 64'(prev + 34));
    do_op(32'd7, 32'hFFFF_FFFE, 0, 1'b1, c);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, c);
    do_op(32'h1234_5678, 32'd0, 0, 1'b1, c);
    do_op(32'hFFFF_FFFF, 32'h10, 5, 1'b1, c);
    do_op(32'd0, 32'hFFFF_FFF0, 0, 1'b1, c);

    // Abandon 55 / 5 mid-iteration; no pulse may follow.
    do_op(32'd55, 32'd5, 0, 1'b0, c);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_u.delete();
    q_s.delete();
    check("ready_after_reset", 64'(readies()), 64'hF);
    do_op(32'd9, 32'd3, 0, 1'b1, c);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 7);
      a    = $urandom();
      b    = $urandom();
      gap  = $urandom_range(0, 3);
      case (kind)
        0: b = 32'd0;
        1: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(a, b, gap, 1'b1, c);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(q_u.size() + q_s.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mydiv_axis.md
# mydiv_axis

Iterative 32-bit radix-2 restoring divider with AXI-stream-style operand inputs and a result output. It is the responder end of the divider handshake driven by the execute stage. The execute stage offers dividend and divisor on separate valid/ready channels and waits for a one-cycle result-valid pulse. One instance is built per signedness (SIGNED=0 for DIVU, SIGNED=1 for DIV), replacing the vendor divider IP.

## Interface
- SIGNED, default 0: 0 = unsigned division, 1 = two's-complement signed division.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axis_dividend_tdata  in  32  dividend
- s_axis_dividend_tvalid  in  1  dividend offered
- s_axis_dividend_tready  out  1  dividend channel can accept
- s_axis_divisor_tdata  in  32  divisor
- s_axis_divisor_tvalid  in  1  divisor offered
- s_axis_divisor_tready  out  1  divisor channel can accept
- m_axis_dout_tdata  out  64  {quotient[63:32], remainder[31:0]}
- m_axis_dout_tvalid  out  1  result valid, one-cycle pulse, no back-pressure

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Each operand channel has a captured flag.
  - tready of a channel = (state==IDLE) && !captured.
  - A handshake (tvalid && tready) latches that operand and sets its flag.
  - The channels are independent, so both may complete in the same cycle or in different cycles.
- When both operands are held (including the edge that accepts the last one):
  - Load magnitudes: with SIGNED=1 take the absolute value of negative operands; otherwise use the raw operands.
  - Record the quotient sign = sign(dividend) ^ sign(divisor) and the remainder sign = sign(dividend); both are 0 when SIGNED=0.
  - Clear the 33-bit partial remainder and the 6-bit iteration counter, then go to BUSY.
- BUSY, one iteration per cycle, MSB first:
  - rem = {rem[31:0], next dividend bit}.
  - If rem >= {1'b0, |divisor|}: rem -= |divisor| and the quotient bit = 1; otherwise the bit = 0.
  - After the 32nd iteration, go to DONE.
- Entering DONE:
  - Apply the signs: negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Register the result into m_axis_dout_tdata.
- DONE:
  - m_axis_dout_tvalid = 1 for exactly this one cycle.
  - Clear both captured flags and return to IDLE on the next edge.
- m_axis_dout_tdata holds the last result until the next DONE.
- Arithmetic rules:
  - Divisor 0, either mode: quotient = 0xFFFFFFFF and remainder = dividend, as raw input bits. This overrides the sign fix-up.
  - SIGNED=1, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This is the natural result of the magnitude path and needs no special case.
  - The remainder sign always follows the dividend. A zero remainder stays 0.
- Operand tdata is sampled only on its handshake edge. Changes after acceptance are ignored.

## Timing
- Reset, with priority over all handshakes:
  - state = IDLE, captured flags = 0, counter = 0.
  - m_axis_dout_tvalid = 0 and m_axis_dout_tdata = 0.
  - After the first reset edge, both tready = 1.
- Latency: if the last operand is accepted at edge E0, m_axis_dout_tvalid is high in the cycle after edge E32 (i.e. the 33rd cycle after E0) and low otherwise.
- Both tready stay 0 from E0 until the cycle after the DONE cycle, so the earliest next acceptance is edge E34.
- Staggered operands: once a channel's operand is captured, that channel's tready drops the next cycle. The other channel stays ready until its own handshake.
- Reset mid-BUSY or in DONE:
  - The operation is abandoned and no valid pulse is produced.
  - Both tready are high the cycle after reset deasserts.
- tvalid asserted without tready has no effect. tvalid may drop without a handshake.

## Test plan
- Unsigned 100 / 7, both channels valid at cycle 0 -> tready low from cycle 1; dout_tvalid high only in cycle 33; tdata = {0x0000000E, 0x00000002}.
- SIGNED=1, -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 -> {0xFFFFFFFD, 0x00000001}.
- SIGNED=1, 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}. Divide by zero, 0x12345678 / 0 in both modes -> {0xFFFFFFFF, 0x12345678}.
- Dividend 0xFFFFFFFF valid at cycle 0, divisor 0x10 valid at cycle 5, unsigned:
  - dividend tready is low in cycles 1-5; divisor tready is high until it is accepted.
  - Result {0x0FFFFFFF, 0x0000000F} is valid in cycle 38.
- Reset asserted for one cycle at iteration 10 of 55 / 5 -> no dout_tvalid pulse. Then 9 / 3 issued immediately -> {3, 0} after 33 cycles.
- Back-to-back operations, with tvalid held high again the cycle after a result -> second acceptance at edge E34. Each result pulses exactly once and tdata holds between the pulses.
